// File: rtl/sync_updown_mod_counter.sv
// ---------------------------------------------------------------------------
// sync_updown_mod_counter
//   Synchronous mod-MODULUS up/down counter with parallel load, a
//   combinational terminal-count output for cascading and a registered
//   one-cycle wrap pulse. Every bit changes on the same clk edge, so the
//   outputs have no ripple glitches. With MODULUS=10 it counts as a BCD
//   digit. To build a multi-digit counter, connect tc of stage k to en of
//   stage k+1.
//
// Parameters
//   WIDTH      counter width in bits (>= 1)
//   MODULUS    count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
//   RESET_VAL  value of q after reset, < MODULUS
//
// Ports
//   clk       in   1      rising-edge clock
//   rst_n     in   1      synchronous active-low reset
//   en        in   1      count enable
//   up_dn     in   1      1 = count up, 0 = count down
//   load      in   1      parallel load strobe (overrides en)
//   load_val  in   WIDTH  value to load; values >= MODULUS clamp to MODULUS-1
//   q         out  WIDTH  registered count
//   tc        out  1      terminal count, combinational (cascade carry/borrow)
//   wrap      out  1      registered pulse in the cycle after a boundary crossing
//
// Configuration
//   COUNTER_SAT_EN  when defined, the counter saturates at the boundary in the
//                   current direction instead of wrapping, and wrap stays 0.
//                   tc still flags the limit. When undefined (the default), the
//                   counter wraps modulo MODULUS.
// ---------------------------------------------------------------------------
module sync_updown_mod_counter #(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 16,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    // Reject illegal parameter combinations while the design is elaborated.
    if (MODULUS < 2 || MODULUS > (2 ** WIDTH) || RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_param_err
        $error("sync_updown_mod_counter: illegal WIDTH/MODULUS/RESET_VAL combination");
    end

    // The largest legal count always fits in WIDTH bits because MODULUS <= 2**WIDTH,
    // so every comparison below can be done at WIDTH bits.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VAL);

    logic at_limit;

    // at_limit is high when q sits on the boundary in the selected direction:
    // MODULUS-1 when counting up, 0 when counting down.
    assign at_limit = up_dn ? (q == MAX_VAL) : (q == '0);

    // tc ignores load and reset. A cascaded stage sees the carry in the same
    // cycle that this stage samples its wrapping edge.
    assign tc = en & at_limit;

    // NOTE: q and wrap are flops. Non-blocking assignments let every bit
    // update from the same pre-edge values. The reset is synchronous, so it
    // is handled as the highest-priority branch inside the clocked block
    // rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q    <= RST_Q;
            wrap <= 1'b0;
        end else if (load) begin
            // Clamp an out-of-range load so q can never leave 0..MODULUS-1.
            q    <= (load_val > MAX_VAL) ? MAX_VAL : load_val;
            wrap <= 1'b0;
        end else if (en) begin
            if (at_limit) begin
`ifdef COUNTER_SAT_EN
                q    <= q;
                wrap <= 1'b0;
`else
                q    <= up_dn ? '0 : MAX_VAL;
                wrap <= 1'b1;
`endif
            end else begin
                q    <= up_dn ? q + 1'b1 : q - 1'b1;
                wrap <= 1'b0;
            end
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sync_updown_mod_counter.sv
// ---------------------------------------------------------------------------
// tb_sync_updown_mod_counter
//   Self-checking bench for sync_updown_mod_counter (WIDTH=4, MODULUS=10).
//   The driver applies one set of inputs per cycle. For each cycle it pushes
//   the values expected on q, wrap and tc into a queue, using a plain-arithmetic
//   model, and then advances the model. A separate monitor pops one entry per
//   cycle at the falling edge and compares it with the outputs.
//   Two more instances form a cascaded 00..99 counter (tc0 -> en1). The model
//   tracks it as a single integer modulo 100.
// ---------------------------------------------------------------------------
module tb_sync_updown_mod_counter;

    localparam int W = 4;
    localparam int M = 10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         up_dn = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] q;
    logic         tc;
    logic         wrap;

    // Cascade: stage 0 always counts up. Stage 1 is enabled by tc0.
    logic [W-1:0] q0, q1;
    logic         tc0, tc1, wrap0, wrap1;

    always #5 clk = ~clk;

    sync_updown_mod_counter #(.WIDTH(W), .MODULUS(M), .RESET_VAL(0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .q(q), .tc(tc), .wrap(wrap)
    );

    sync_updown_mod_counter #(.WIDTH(W), .MODULUS(M), .RESET_VAL(0)) u_c0 (
        .clk(clk), .rst_n(rst_n), .en(1'b1), .up_dn(1'b1), .load(1'b0),
        .load_val('0), .q(q0), .tc(tc0), .wrap(wrap0)
    );

    sync_updown_mod_counter #(.WIDTH(W), .MODULUS(M), .RESET_VAL(0)) u_c1 (
        .clk(clk), .rst_n(rst_n), .en(tc0), .up_dn(1'b1), .load(1'b0),
        .load_val('0), .q(q1), .tc(tc1), .wrap(wrap1)
    );

    typedef struct {
        int q;
        bit wrap;
        bit tc;
        int c_val;
        bit c_wrap;
    } exp_t;

    exp_t sb[$];

    int errors = 0;
    int checks = 0;
    int wrap1_seen = 0;

    // Reference-model state.
    bit known = 1'b0;
    int m_q = 0;
    bit m_wrap = 1'b0;
    int c_cnt = 0;
    bit c_wrap = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Apply one cycle of stimulus and record what the outputs must show in
    // this cycle. The model then takes the next clock edge.
    task automatic drive(input bit r, input bit e, input bit u, input bit l, input int lv);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n    = r;
        en       = e;
        up_dn    = u;
        load     = l;
        load_val = W'(lv);
        if (known) begin
            x.q      = m_q;
            x.wrap   = m_wrap;
            x.tc     = e && (u ? (m_q == M - 1) : (m_q == 0));
            x.c_val  = c_cnt;
            x.c_wrap = c_wrap;
            sb.push_back(x);
        end
        if (!r) begin
            m_q    = 0;
            m_wrap = 1'b0;
            c_cnt  = 0;
            c_wrap = 1'b0;
            known  = 1'b1;
        end else begin
            if (l) begin
                m_q    = (lv > M - 1) ? M - 1 : lv;
                m_wrap = 1'b0;
            end else if (e) begin
`ifdef COUNTER_SAT_EN
                m_wrap = 1'b0;
                if (u) m_q = (m_q + 1 > M - 1) ? M - 1 : m_q + 1;
                else   m_q = (m_q == 0) ? 0 : m_q - 1;
`else
                m_wrap = u ? (m_q == M - 1) : (m_q == 0);
                m_q    = u ? (m_q + 1) % M : (m_q + M - 1) % M;
`endif
            end else begin
                m_wrap = 1'b0;
            end
`ifdef COUNTER_SAT_EN
            c_wrap = 1'b0;
            c_cnt  = (c_cnt == 99) ? 99 : c_cnt + 1;
`else
            c_wrap = (c_cnt == 99);
            c_cnt  = (c_cnt + 1) % 100;
`endif
        end
    endtask

    // Monitor: the DUT shows a fresh result every cycle. Compare it with the
    // oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("q",     {28'b0, q},  e.q);
            check("wrap",  {31'b0, wrap}, {31'b0, e.wrap});
            check("tc",    {31'b0, tc},   {31'b0, e.tc});
            check("cascade_q", int'(q1) * 10 + int'(q0), e.c_val);
            check("cascade_wrap1", {31'b0, wrap1}, {31'b0, e.c_wrap});
            if (wrap1) wrap1_seen++;
        end
    end

    initial begin
        // Reset for two cycles with en high.
        drive(0, 1, 1, 0, 0);
        drive(0, 1, 1, 0, 0);
        // Twelve up counts through the 9 -> 0 boundary.
        for (int i = 0; i < 12; i++) drive(1, 1, 1, 0, 0);
        // Load 3, then count down five times through 0 -> 9.
        drive(1, 1, 0, 1, 3);
        for (int i = 0; i < 5; i++) drive(1, 1, 0, 0, 0);
        // A clamped load, then a load that competes with en.
        drive(1, 0, 1, 1, 13);
        drive(1, 1, 1, 1, 5);
        // Count up to 7. Reset together with load, then hold.
        drive(1, 1, 1, 0, 0);
        drive(1, 1, 1, 0, 0);
        drive(1, 1, 1, 1, 8);
        drive(0, 1, 1, 1, 7);
        for (int i = 0; i < 4; i++) drive(1, 0, $urandom_range(1), 0, 0);
        // Saturation boundary: up from 8, then turn back.
        drive(1, 0, 1, 1, 8);
        for (int i = 0; i < 4; i++) drive(1, 1, 1, 0, 0);
        drive(1, 1, 0, 0, 0);
        // Random traffic without reset, long enough for the cascade to walk 00..99.
        for (int i = 0; i < 220; i++)
            drive(1, $urandom_range(3) != 0, $urandom_range(1),
                  $urandom_range(7) == 0, $urandom_range(15));
        // Random traffic with occasional resets.
        for (int i = 0; i < 300; i++)
            drive($urandom_range(63) != 0, $urandom_range(3) != 0, $urandom_range(1),
                  $urandom_range(7) == 0, $urandom_range(15));
        drive(1, 0, 1, 0, 0);

        // Let the monitor drain the queue, with a bound.
        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
`ifndef COUNTER_SAT_EN
        checks++;
        if (wrap1_seen < 2) begin
            errors++;
            $display("FAIL cascade_wrap_count: got %0d, expected at least 2", wrap1_seen);
        end
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
